// File: rtl/ela_field_feeder_pkg.sv
// Shared constants and FSM encoding for the ELA field feeder.
// The ELA side imports the same sizes so both ends of the row interface agree.
package ela_field_feeder_pkg;

  localparam int COLS = 128;
  localparam int ROWS = 32;
  localparam int DW   = 8;
  localparam int AW   = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_WAIT,
    ST_STREAM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ela_field_feeder_if.sv
// Row-serving and source-SRAM signals of the field feeder, bundled as one port.
// The master modport is the feeder; the slave modport is its environment (ELA, SRAM, control).
interface ela_field_feeder_if #(
  parameter int DW = 8,
  parameter int AW = 13
);
  logic          start;
  logic          req;
  logic          ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] src_addr;
  logic          src_ren;
  logic [DW-1:0] src_rdata;
  logic [4:0]    row_idx;
  logic          frame_done;
  logic          err;

  modport master (
    input  start, req, src_rdata,
    output ready, in_data, src_addr, src_ren, row_idx, frame_done, err
  );

  modport slave (
    output start, req, src_rdata,
    input  ready, in_data, src_addr, src_ren, row_idx, frame_done, err
  );
endinterface

// File: rtl/ela_field_feeder.sv
// Reads one field of an interlaced frame from a 1-cycle-latency SRAM and serves it
// row by row to the ELA, prefetching the next row's pixel 0 so rows follow with no bubble.
module ela_field_feeder
  import ela_field_feeder_pkg::*;
#(
  parameter int COLS  = ela_field_feeder_pkg::COLS,
  parameter int ROWS  = ela_field_feeder_pkg::ROWS,
  parameter int FIELD = 0,
  parameter int DW    = ela_field_feeder_pkg::DW,
  parameter int AW    = ela_field_feeder_pkg::AW
) (
  input  logic               clk,
  input  logic               rst,
  ela_field_feeder_if.master bus
);

  localparam int CW = $clog2(COLS);

  state_t        state_q, state_d;
  logic [CW-1:0] col_q;
  logic [4:0]    row_q;
  logic          err_q;

  logic          start_ok;
  logic          accept_req;
  logic          last_col;
  logic          last_row;
  logic          proto_err;

  assign start_ok   = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign accept_req = bus.req && (state_q == ST_WAIT);
  assign last_col   = (col_q == CW'(COLS - 1));
  assign last_row   = (row_q == 5'(ROWS - 1));

  // In WAIT, a simultaneous start loses to req and is only flagged.
  assign proto_err = (bus.req && state_q != ST_WAIT) ||
                     (bus.start && (state_q == ST_PRIME || state_q == ST_WAIT ||
                                    state_q == ST_STREAM));

  // NOTE: async reset listed in the sensitivity list; all state updates use <= so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_PRIME;
      ST_PRIME:  state_d = ST_WAIT;
      ST_WAIT:   if (bus.req) state_d = ST_STREAM;
      ST_STREAM: if (last_col) state_d = last_row ? ST_DONE : ST_WAIT;
      ST_DONE:   if (bus.start) state_d = ST_PRIME;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (start_ok) begin
        col_q <= '0;
        row_q <= '0;
      end else if (accept_req) begin
        col_q <= col_q + CW'(1);
      end else if (state_q == ST_STREAM) begin
        col_q <= col_q + CW'(1);
        if (last_col && !last_row) row_q <= row_q + 5'd1;
      end

      // An accepted start clears the sticky flag, but an error in that same cycle still counts.
      if (start_ok) err_q <= proto_err;
      else          err_q <= err_q | proto_err;
    end
  end

  // Address generator: look one pixel ahead so SRAM latency is hidden, and at the end of a
  // row jump straight to the next row's pixel 0.
  logic [4:0]    addr_row;
  logic [CW-1:0] col_next;
  logic [AW-1:0] frame_line;
  logic [AW-1:0] row_base;

  always_comb begin
    addr_row = row_q;
    if (state_q == ST_STREAM && last_col && !last_row) addr_row = row_q + 5'd1;
    col_next = col_q;
    if (state_q == ST_STREAM || accept_req) col_next = col_q + CW'(1);
    frame_line = (AW'(addr_row) << 1) + AW'(FIELD);
    row_base   = frame_line << CW;
  end

  always_comb begin
    bus.ready      = 1'b0;
    bus.src_ren    = 1'b0;
    bus.frame_done = 1'b0;
    case (state_q)
      ST_PRIME:  bus.src_ren = 1'b1;
      ST_WAIT,
      ST_STREAM: begin
        bus.ready   = 1'b1;
        bus.src_ren = 1'b1;
      end
      ST_DONE:   bus.frame_done = 1'b1;
      default:   ;
    endcase
  end

  assign bus.src_addr = bus.src_ren ? (row_base + AW'(col_next)) : '0;
  assign bus.in_data  = bus.src_rdata;
  assign bus.row_idx  = row_q;
  assign bus.err      = err_q;

endmodule
